regfile_mp_bypass: RTL and testbench
====================================

Name: regfile_mp_bypass

Overview:
- Parametrised multi-port register file; next generation of the processor's integer register file.
- Configurable data width, depth, read-port count and write-port count.
- Adds same-cycle write-to-read bypass, a per-register busy scoreboard for hazard detection, and a post-reset zeroing sweep suitable for RAM-style storage.
- Sits between decode (reads, issue marking) and writeback (writes, busy clear).

Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of registers; power of 2, at least 2.
- AW, $clog2(DEPTH), address width.
- NUM_RD, 2, number of read ports.
- NUM_WR, 2, number of write ports.
- BYPASS, 1, 1 = write data forwarded to same-cycle reads; 0 = writes visible next cycle only.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- rd_addr  in  NUM_RD*AW  read addresses; port i at [i*AW +: AW].
- rd_data  out  NUM_RD*DW  read data; port i at [i*DW +: DW].
- rd_busy  out  NUM_RD  scoreboard bit for each read address.
- wr_en  in  NUM_WR  write enables.
- wr_addr  in  NUM_WR*AW  write addresses.
- wr_data  in  NUM_WR*DW  write data.
- issue_en  in  1  mark issue_addr busy (pending producer).
- issue_addr  in  AW  destination register being issued.
- ready  out  1  high once the init sweep is done; writes and issues are accepted only while high.

Behaviour:
Clock and reset:
- One clock domain, clk.
- reset is synchronous and active-low: sampled on the rising edge of clk when low.
- While reset is low: state goes to INIT, sweep pointer to 0, all busy bits to 0, ready to 0.
- Asserting reset mid-operation (including mid-sweep) restarts the sweep from entry 0.

State machine:
- INIT:
  - Each cycle writes 0 to entry ptr, then ptr increments.
  - When ptr == DEPTH-1 is written, the next state is RUN. ready goes to 1 on that edge.
  - The sweep takes exactly DEPTH cycles after reset is released.
  - wr_en and issue_en are ignored.
  - rd_data is forced to 0 and rd_busy to 0.
- RUN: normal operation. No exit except reset.

Reads:
- Combinational from rd_addr.
- Address 0 always reads 0 and is never busy.
- With BYPASS=1: if any enabled write port targets rd_addr (nonzero) in the same cycle, rd_data returns that write data. The highest-indexed matching port wins.
- With BYPASS=0: rd_data returns stored contents.

Writes:
- Take effect at the rising edge.
- Writes to address 0 are discarded.
- Several ports writing the same address in one cycle: the highest-indexed port wins, for both storage and bypass.

Scoreboard:
- One busy bit per register; bit 0 is tied to 0.
- issue_en (nonzero issue_addr) sets busy[issue_addr] at the next edge.
- Any enabled write clears busy[wr_addr] at the next edge.
- Issue and write to the same address in the same cycle: busy stays 1, because the new producer wins.
- rd_busy[i] = busy[rd_addr[i]].
  - With BYPASS=1, rd_busy is 0 for a port whose address matches a same-cycle write, since the value is being forwarded.

Arithmetic:
- No arithmetic on data.
- Pointer is AW bits wide; no wrap occurs because INIT exits at DEPTH-1.

Decomposition:
- Shared package (rf_pkg): default DW, DEPTH, NUM_RD, NUM_WR; state encoding RF_INIT=1'b0, RF_RUN=1'b1; zero constant.
- One natural sub-module: rf_write_arb.
  - Per-address priority selection across the NUM_WR write ports.
  - Outputs a hit flag and the selected data for a given address.
  - Instantiated once per read port for bypass, and used for storage update.

Test Plan:
- Release reset at cycle 0, DEPTH=32 -> ready=0 for 32 cycles, 1 on cycle 32. Reads of any address during the sweep return 0x0. Writes issued during INIT are not retained.
- RUN: write port0 addr 5 = 0xDEADBEEF; same cycle read addr 5 -> rd_data 0xDEADBEEF with BYPASS=1, old value with BYPASS=0. Next cycle read -> 0xDEADBEEF in both modes.
- Both ports write addr 7 (port0 0x11, port1 0x22) -> stored and bypassed value 0x22. Write addr 0 = 0xFFFF -> reads 0.
- issue addr 9 -> rd_busy=1 next cycle. Write addr 9 -> rd_busy=0 after the edge. Issue and write addr 9 in the same cycle -> busy remains 1. Issue addr 0 -> never busy.
- Assert reset mid-sweep at cycle 10 for 1 cycle -> ready stays 0 until 32 cycles after release. All busy bits cleared.
- Parameter sweep DW=64, DEPTH=16, NUM_RD=4, NUM_WR=3 -> repeat the scenarios above. The sweep takes 16 cycles and all 4 read ports bypass correctly.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared defaults and state encoding for the multi-port register file.
package rf_pkg;

  localparam int unsigned DEF_DW     = 32;
  localparam int unsigned DEF_DEPTH  = 32;
  localparam int unsigned DEF_NUM_RD = 2;
  localparam int unsigned DEF_NUM_WR = 2;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  // Hardwired-zero register index.
  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/regfile_mp_bypass_if.sv
// Decode/writeback bundle for the register file: read ports, write ports and issue marking.
interface regfile_mp_bypass_if #(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2
);

  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD*DW-1:0] rd_data;
  logic [NUM_RD-1:0]    rd_busy;
  logic [NUM_WR-1:0]    wr_en;
  logic [NUM_WR*AW-1:0] wr_addr;
  logic [NUM_WR*DW-1:0] wr_data;
  logic                 issue_en;
  logic [AW-1:0]        issue_addr;
  logic                 ready;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
    input  rd_data, rd_busy, ready
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
    output rd_data, rd_busy, ready
  );

endinterface

// File: rtl/rf_write_arb.sv
// Priority select across write ports for one address; the highest-indexed matching port wins.
module rf_write_arb
  import rf_pkg::*;
#(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned NUM_WR = 2
) (
  input  logic [AW-1:0]        addr_i,
  input  logic [NUM_WR-1:0]    wr_en_i,
  input  logic [NUM_WR*AW-1:0] wr_addr_i,
  input  logic [NUM_WR*DW-1:0] wr_data_i,
  output logic                 hit_o,
  output logic [DW-1:0]        data_o
);

  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] == addr_i) && (addr_i != AW'(ZERO_REG))) begin
        hit_o  = 1'b1;
        data_o = wr_data_i[w*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/regfile_mp_bypass.sv
// Multi-port register file with same-cycle write bypass, busy scoreboard and post-reset zero sweep.
module regfile_mp_bypass
  import rf_pkg::*;
#(
  parameter int unsigned DW     = DEF_DW,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned AW     = $clog2(DEPTH),
  parameter int unsigned NUM_RD = DEF_NUM_RD,
  parameter int unsigned NUM_WR = DEF_NUM_WR,
  parameter int unsigned BYPASS = 1
) (
  input logic                clk,
  input logic                reset,
  regfile_mp_bypass_if.slave bus
);

  rf_state_e         state_q;
  logic [AW-1:0]     ptr_q;
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DW-1:0]     mem_q [DEPTH];
  logic              accept;
  logic [NUM_WR-1:0] wr_en_acc;
  logic [DEPTH-1:0]  st_hit;
  logic [DW-1:0]     st_data [DEPTH];
  logic [NUM_RD-1:0] byp_hit;
  logic [DW-1:0]     byp_data [NUM_RD];
  logic [AW-1:0]     rd_a;

  // Writes and issues only count in RUN with reset released.
  assign accept    = (state_q == RF_RUN) && reset;
  assign wr_en_acc = accept ? bus.wr_en : '0;
  assign bus.ready = (state_q == RF_RUN);

  for (genvar e = 0; e < DEPTH; e++) begin : g_store
    rf_write_arb #(
      .DW     (DW),
      .AW     (AW),
      .NUM_WR (NUM_WR)
    ) u_arb (
      .addr_i    (AW'(e)),
      .wr_en_i   (wr_en_acc),
      .wr_addr_i (bus.wr_addr),
      .wr_data_i (bus.wr_data),
      .hit_o     (st_hit[e]),
      .data_o    (st_data[e])
    );
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_byp
    rf_write_arb #(
      .DW     (DW),
      .AW     (AW),
      .NUM_WR (NUM_WR)
    ) u_arb (
      .addr_i    (bus.rd_addr[r*AW +: AW]),
      .wr_en_i   (wr_en_acc),
      .wr_addr_i (bus.wr_addr),
      .wr_data_i (bus.wr_data),
      .hit_o     (byp_hit[r]),
      .data_o    (byp_data[r])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RF_INIT;
      ptr_q   <= '0;
      busy_q  <= '0;
    end else begin
      unique case (state_q)
        RF_INIT: begin
          if (ptr_q == AW'(DEPTH - 1)) state_q <= RF_RUN;
          else                         ptr_q   <= ptr_q + 1'b1;
        end
        RF_RUN: busy_q <= busy_d;
      endcase
    end
  end

  // Storage has no reset; the INIT sweep zeroes one entry per cycle.
  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if ((state_q == RF_INIT) && (ptr_q == AW'(e))) mem_q[e] <= '0;
      else if (st_hit[e])                            mem_q[e] <= st_data[e];
    end
  end

  // A same-cycle issue overrides the clear from a write: the new producer wins.
  always_comb begin
    busy_d = busy_q & ~st_hit;
    if (accept && bus.issue_en) busy_d[bus.issue_addr] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
  end

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    rd_a        = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      rd_a = bus.rd_addr[r*AW +: AW];
      if ((state_q == RF_RUN) && (rd_a != AW'(ZERO_REG))) begin
        if ((BYPASS != 0) && byp_hit[r]) begin
          bus.rd_data[r*DW +: DW] = byp_data[r];
        end else begin
          bus.rd_data[r*DW +: DW] = mem_q[rd_a];
          bus.rd_busy[r]          = busy_q[rd_a];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_bypass.sv
// Randomised bench for regfile_mp_bypass over three configurations against a behavioural model.
module tb_regfile_mp_bypass;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_n;
  logic [4:0]  g_rd_addr [4];
  logic [2:0]  g_wr_en;
  logic [4:0]  g_wr_addr [3];
  logic [63:0] g_wr_data [3];
  logic        g_issue_en;
  logic [4:0]  g_issue_addr;

  // Config 0: defaults, bypass. Config 1: wide/shallow, bypass. Config 2: defaults, no bypass.
  regfile_mp_bypass_if #(.DW(32), .AW(5), .NUM_RD(2), .NUM_WR(2)) if_a ();
  regfile_mp_bypass_if #(.DW(64), .AW(4), .NUM_RD(4), .NUM_WR(3)) if_b ();
  regfile_mp_bypass_if #(.DW(32), .AW(5), .NUM_RD(2), .NUM_WR(2)) if_c ();

  assign if_a.rd_addr    = {g_rd_addr[1], g_rd_addr[0]};
  assign if_a.wr_en      = g_wr_en[1:0];
  assign if_a.wr_addr    = {g_wr_addr[1], g_wr_addr[0]};
  assign if_a.wr_data    = {g_wr_data[1][31:0], g_wr_data[0][31:0]};
  assign if_a.issue_en   = g_issue_en;
  assign if_a.issue_addr = g_issue_addr;

  assign if_c.rd_addr    = {g_rd_addr[1], g_rd_addr[0]};
  assign if_c.wr_en      = g_wr_en[1:0];
  assign if_c.wr_addr    = {g_wr_addr[1], g_wr_addr[0]};
  assign if_c.wr_data    = {g_wr_data[1][31:0], g_wr_data[0][31:0]};
  assign if_c.issue_en   = g_issue_en;
  assign if_c.issue_addr = g_issue_addr;

  assign if_b.rd_addr    = {g_rd_addr[3][3:0], g_rd_addr[2][3:0], g_rd_addr[1][3:0],
                            g_rd_addr[0][3:0]};
  assign if_b.wr_en      = g_wr_en;
  assign if_b.wr_addr    = {g_wr_addr[2][3:0], g_wr_addr[1][3:0], g_wr_addr[0][3:0]};
  assign if_b.wr_data    = {g_wr_data[2], g_wr_data[1], g_wr_data[0]};
  assign if_b.issue_en   = g_issue_en;
  assign if_b.issue_addr = g_issue_addr[3:0];

  regfile_mp_bypass #(.DW(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) u_dut_a (
    .clk   (clk),
    .reset (rst_n[0]),
    .bus   (if_a)
  );
  regfile_mp_bypass #(.DW(64), .DEPTH(16), .NUM_RD(4), .NUM_WR(3), .BYPASS(1)) u_dut_b (
    .clk   (clk),
    .reset (rst_n[1]),
    .bus   (if_b)
  );
  regfile_mp_bypass #(.DW(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(0)) u_dut_c (
    .clk   (clk),
    .reset (rst_n[2]),
    .bus   (if_c)
  );

  int n_vec, n_err;
  int cfg, dw, depth, nrd, nwr, byp;
  logic [63:0] dmask;

  // Behavioural model: architectural contents, busy flags, reset-release edge count.
  logic [63:0] m_mem [32];
  logic        m_busy [32];
  int          m_cnt;
  bit          m_valid;

  function automatic logic [63:0] act_data(input int c, input int r);
    case (c)
      0:       return {32'b0, if_a.rd_data[r*32 +: 32]};
      1:       return if_b.rd_data[r*64 +: 64];
      default: return {32'b0, if_c.rd_data[r*32 +: 32]};
    endcase
  endfunction

  function automatic logic act_busy(input int c, input int r);
    case (c)
      0:       return if_a.rd_busy[r];
      1:       return if_b.rd_busy[r];
      default: return if_c.rd_busy[r];
    endcase
  endfunction

  function automatic logic act_ready(input int c);
    case (c)
      0:       return if_a.ready;
      1:       return if_b.ready;
      default: return if_c.ready;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cfg=%0d t=%0t got=%h want=%h", name, cfg, $time, act, exp);
    end
  endtask

  function automatic int amask(input logic [4:0] a);
    return int'(a) & (depth - 1);
  endfunction

  function automatic void exp_read(input int a, output logic [63:0] d, output logic b);
    d = '0;
    b = 1'b0;
    if (m_cnt < depth || a == 0) return;
    d = m_mem[a];
    b = m_busy[a];
    if (byp != 0) begin
      for (int w = 0; w < nwr; w++) begin
        if (g_wr_en[w] && amask(g_wr_addr[w]) == a) begin
          d = g_wr_data[w] & dmask;
          b = 1'b0;
        end
      end
    end
  endfunction

  task automatic model_check();
    logic [63:0] ed;
    logic        eb;
    if (!m_valid) return;
    check("ready", {63'b0, act_ready(cfg)}, {63'b0, (m_cnt >= depth)});
    for (int r = 0; r < nrd; r++) begin
      exp_read(amask(g_rd_addr[r]), ed, eb);
      check($sformatf("rd_data[%0d]", r), act_data(cfg, r), ed);
      check($sformatf("rd_busy[%0d]", r), {63'b0, act_busy(cfg, r)}, {63'b0, eb});
    end
  endtask

  task automatic model_update();
    int a;
    if (!rst_n[cfg]) begin
      m_cnt   = 0;
      m_valid = 1'b1;
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else if (m_cnt < depth) begin
      m_cnt++;
      if (m_cnt == depth) for (int i = 0; i < 32; i++) m_mem[i] = '0;
    end else begin
      for (int w = 0; w < nwr; w++) begin
        a = amask(g_wr_addr[w]);
        if (g_wr_en[w] && a != 0) begin
          m_mem[a]  = g_wr_data[w] & dmask;
          m_busy[a] = 1'b0;
        end
      end
      a = amask(g_issue_addr);
      if (g_issue_en && a != 0) m_busy[a] = 1'b1;
    end
  endtask

  // Inputs are driven just after negedge; check mid-cycle, update the model at posedge.
  task automatic tick();
    #1;
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_idle();
    for (int r = 0; r < 4; r++) g_rd_addr[r] = '0;
    for (int w = 0; w < 3; w++) begin
      g_wr_addr[w] = '0;
      g_wr_data[w] = '0;
    end
    g_wr_en      = '0;
    g_issue_en   = 1'b0;
    g_issue_addr = '0;
  endtask

  task automatic read_all(input logic [4:0] a);
    for (int r = 0; r < 4; r++) g_rd_addr[r] = a;
  endtask

  function automatic logic [4:0] pick_addr();
    if ($urandom_range(0, 2) == 0) return 5'($urandom_range(0, 3));
    return 5'($urandom_range(0, 31));
  endfunction

  task automatic rand_inputs();
    for (int w = 0; w < 3; w++) begin
      g_wr_en[w]   = 1'($urandom_range(0, 1));
      g_wr_addr[w] = pick_addr();
      g_wr_data[w] = {$urandom, $urandom};
    end
    for (int r = 0; r < 4; r++) begin
      g_rd_addr[r] = pick_addr();
      if ($urandom_range(0, 2) == 0) g_rd_addr[r] = g_wr_addr[$urandom_range(0, nwr - 1)];
    end
    g_issue_en   = ($urandom_range(0, 2) == 0);
    g_issue_addr = pick_addr();
  endtask

  task automatic set_cfg(input int c);
    cfg     = c;
    dw      = (c == 1) ? 64 : 32;
    depth   = (c == 1) ? 16 : 32;
    nrd     = (c == 1) ? 4 : 2;
    nwr     = (c == 1) ? 3 : 2;
    byp     = (c == 2) ? 0 : 1;
    dmask   = (dw == 64) ? '1 : ((64'd1 << dw) - 64'd1);
    m_valid = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic run_cfg(input int c);
    logic [63:0] exp7;
    set_cfg(c);
    set_idle();
    rst_n = '0;
    tick();
    tick();
    #1 check("ready_in_reset", {63'b0, act_ready(cfg)}, 64'd0);
    rst_n[cfg] = 1'b1;

    // Sweep: stray writes/issues to address 5 must be dropped.
    for (int k = 0; k < depth; k++) begin
      g_wr_en = '1;
      for (int w = 0; w < 3; w++) begin
        g_wr_addr[w] = 5'd5;
        g_wr_data[w] = 64'hAAAA_5555_AAAA_5555;
      end
      g_issue_en   = 1'b1;
      g_issue_addr = 5'd5;
      read_all(5'd5);
      #1;
      check("sweep_ready", {63'b0, act_ready(cfg)}, 64'd0);
      check("sweep_rd", act_data(cfg, 0), 64'd0);
      tick();
    end
    set_idle();
    read_all(5'd5);
    #1;
    check("ready_after_sweep", {63'b0, act_ready(cfg)}, 64'd1);
    check("init_write_dropped", act_data(cfg, 0), 64'd0);
    check("init_issue_dropped", {63'b0, act_busy(cfg, 0)}, 64'd0);
    tick();

    // Bypass of a single write on every read port.
    g_wr_en[0] = 1'b1; g_wr_addr[0] = 5'd5; g_wr_data[0] = 64'hDEADBEEF;
    read_all(5'd5);
    #1;
    for (int r = 0; r < nrd; r++)
      check("byp_same_cycle", act_data(cfg, r), (byp != 0) ? 64'hDEADBEEF : 64'd0);
    tick();
    set_idle();
    read_all(5'd5);
    #1;
    for (int r = 0; r < nrd; r++) check("stored_5", act_data(cfg, r), 64'hDEADBEEF);
    tick();

    // All write ports hit address 7; the top port wins.
    exp7 = (nwr == 3) ? 64'h33 : 64'h22;
    g_wr_en = '1;
    for (int w = 0; w < 3; w++) begin
      g_wr_addr[w] = 5'd7;
      g_wr_data[w] = 64'h11 * 64'(w + 1);
    end
    read_all(5'd7);
    #1 check("multi_wr_byp", act_data(cfg, nrd - 1), (byp != 0) ? exp7 : 64'd0);
    tick();
    set_idle();
    read_all(5'd7);
    #1 check("multi_wr_stored", act_data(cfg, 0), exp7);
    tick();

    // Register 0 is hardwired.
    g_wr_en[0] = 1'b1; g_wr_addr[0] = 5'd0; g_wr_data[0] = 64'hFFFF;
    read_all(5'd0);
    #1 check("zero_byp", act_data(cfg, 0), 64'd0);
    tick();
    set_idle();
    #1 check("zero_stored", act_data(cfg, 0), 64'd0);
    tick();

    // Scoreboard.
    g_issue_en = 1'b1; g_issue_addr = 5'd9;
    tick();
    set_idle();
    read_all(5'd9);
    #1 check("busy_after_issue", {63'b0, act_busy(cfg, 0)}, 64'd1);
    tick();
    g_wr_en[0] = 1'b1; g_wr_addr[0] = 5'd9; g_wr_data[0] = 64'h99;
    #1 check("busy_during_wr", {63'b0, act_busy(cfg, 0)}, (byp != 0) ? 64'd0 : 64'd1);
    tick();
    set_idle();
    read_all(5'd9);
    #1;
    check("busy_after_wr", {63'b0, act_busy(cfg, 0)}, 64'd0);
    check("data_after_wr", act_data(cfg, 0), 64'h99);
    tick();
    g_wr_en[0] = 1'b1; g_wr_addr[0] = 5'd9; g_wr_data[0] = 64'h98;
    g_issue_en = 1'b1; g_issue_addr = 5'd9;
    tick();
    set_idle();
    read_all(5'd9);
    #1 check("busy_issue_wins", {63'b0, act_busy(cfg, 0)}, 64'd1);
    tick();
    g_issue_en = 1'b1; g_issue_addr = 5'd0;
    tick();
    set_idle();
    #1 check("busy_zero", {63'b0, act_busy(cfg, 0)}, 64'd0);
    tick();

    for (int k = 0; k < 300; k++) begin
      rand_inputs();
      tick();
    end

    // Reset in the middle of a sweep restarts it and clears busy.
    set_idle();
    g_issue_en = 1'b1; g_issue_addr = 5'd9;
    tick();
    set_idle();
    rst_n[cfg] = 1'b0;
    tick();
    rst_n[cfg] = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    rst_n[cfg] = 1'b0;
    tick();
    rst_n[cfg] = 1'b1;
    for (int k = 0; k < depth; k++) begin
      read_all(pick_addr());
      #1 check("resweep_ready", {63'b0, act_ready(cfg)}, 64'd0);
      tick();
    end
    read_all(5'd9);
    #1;
    check("resweep_done", {63'b0, act_ready(cfg)}, 64'd1);
    check("busy_cleared", {63'b0, act_busy(cfg, 0)}, 64'd0);
    tick();
    rst_n[cfg] = 1'b0;
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst_n   = '0;
    m_valid = 1'b0;
    set_idle();
    @(negedge clk);
    for (int c = 0; c < 3; c++) run_cfg(c);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
